// File: rtl/pe_mac_stream_if.sv
// Operand/result bundle for one output-stationary MAC cell.
// master = neighbour/driver side, slave = the PE itself.
interface pe_mac_stream_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
);
    // row operand stream from west
    logic              row_in_valid;
    logic              row_in_ready;
    logic [DATA_W-1:0] row_in_dat;
    logic              row_in_last;
    // column operand stream from north
    logic              col_in_valid;
    logic              col_in_ready;
    logic [DATA_W-1:0] col_in_dat;
    // forwarded row stream to east
    logic              row_out_valid;
    logic              row_out_ready;
    logic [DATA_W-1:0] row_out_dat;
    logic              row_out_last;
    // forwarded column stream to south
    logic              col_out_valid;
    logic              col_out_ready;
    logic [DATA_W-1:0] col_out_dat;
    // completed dot product
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_dat;
    logic              res_sat;

    modport master (
        output row_in_valid, row_in_dat, row_in_last,
        output col_in_valid, col_in_dat,
        output row_out_ready, col_out_ready, res_ready,
        input  row_in_ready, col_in_ready,
        input  row_out_valid, row_out_dat, row_out_last,
        input  col_out_valid, col_out_dat,
        input  res_valid, res_dat, res_sat
    );

    modport slave (
        input  row_in_valid, row_in_dat, row_in_last,
        input  col_in_valid, col_in_dat,
        input  row_out_ready, col_out_ready, res_ready,
        output row_in_ready, col_in_ready,
        output row_out_valid, row_out_dat, row_out_last,
        output col_out_valid, col_out_dat,
        output res_valid, res_dat, res_sat
    );
endinterface

// File: rtl/pe_mac_stream.sv
// Integer MAC processing element for the output-stationary systolic array.
// Row/col operands are accepted jointly, forwarded east/south through one
// registered slot each, and their signed product is accumulated after a
// MUL_LAT-deep product pipeline. A 'last' tag on the row stream closes the
// dot product into the result register and clears the accumulator.
module pe_mac_stream #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 32,
    parameter int MUL_LAT  = 2,
    parameter int SATURATE = 1
) (
    input  logic           clk,
    input  logic           nrst,
    pe_mac_stream_if.slave bus,
    output logic           error_bit,
    output logic           busy
);
    localparam int PROD_W = 2 * DATA_W;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    generate
        if (ACC_W < 2 * DATA_W) begin : g_bad_acc_w
            $error("pe_mac_stream: ACC_W must be >= 2*DATA_W");
        end
        if (MUL_LAT < 1 || MUL_LAT > 4) begin : g_bad_mul_lat
            $error("pe_mac_stream: MUL_LAT must be 1..4");
        end
    endgenerate

    // forward slots
    logic              r_row_full;
    logic [DATA_W-1:0] r_row_dat;
    logic              r_row_last;
    logic              r_col_full;
    logic [DATA_W-1:0] r_col_dat;

    // product pipeline, stage k lives at index k
    logic [PROD_W-1:0] r_prod [1:MUL_LAT];
    logic [MUL_LAT:1]  r_vld_pipe;
    logic [MUL_LAT:1]  r_last_pipe;

    // accumulator / result
    logic [ACC_W-1:0]  r_acc;
    logic              r_ovf_run;
    logic              r_last_pending;
    logic              r_res_valid;
    logic [ACC_W-1:0]  r_res_dat;
    logic              r_res_sat;
    logic              r_error;

    logic              w_row_free;
    logic              w_col_free;
    logic              w_last_block;
    logic              w_acc;
    logic [PROD_W-1:0] w_prod;
    logic [ACC_W:0]    w_prod_ext;
    logic [ACC_W:0]    w_sum;
    logic              w_ovf;
    logic [ACC_W-1:0]  w_acc_nxt;
    logic              w_mac_vld;
    logic              w_mac_last;

    // A second 'last' may not enter while a closed tile still owns the
    // result register, so the write slot is always free when it lands.
    assign w_row_free   = ~r_row_full | bus.row_out_ready;
    assign w_col_free   = ~r_col_full | bus.col_out_ready;
    assign w_last_block = bus.row_in_last & (r_last_pending | (r_res_valid & ~bus.res_ready));
    // nrst gating keeps the readies low while reset is asserted
    assign w_acc        = nrst & bus.row_in_valid & bus.col_in_valid &
                          w_row_free & w_col_free & ~w_last_block;

    assign bus.row_in_ready  = w_acc;
    assign bus.col_in_ready  = w_acc;
    assign bus.row_out_valid = r_row_full;
    assign bus.row_out_dat   = r_row_dat;
    assign bus.row_out_last  = r_row_last;
    assign bus.col_out_valid = r_col_full;
    assign bus.col_out_dat   = r_col_dat;
    assign bus.res_valid     = r_res_valid;
    assign bus.res_dat       = r_res_dat;
    assign bus.res_sat       = r_res_sat;
    assign error_bit         = r_error;
    assign busy              = (|r_vld_pipe) | r_last_pending | r_res_valid;

    assign w_prod     = $signed(bus.row_in_dat) * $signed(bus.col_in_dat);
    assign w_mac_vld  = r_vld_pipe[MUL_LAT];
    assign w_mac_last = r_last_pipe[MUL_LAT];

    // One guard bit above ACC_W: overflow shows as disagreement of the top two bits.
    assign w_prod_ext = {{(ACC_W+1-PROD_W){r_prod[MUL_LAT][PROD_W-1]}}, r_prod[MUL_LAT]};
    assign w_sum      = {r_acc[ACC_W-1], r_acc} + w_prod_ext;
    assign w_ovf      = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    assign w_acc_nxt  = (w_ovf && SATURATE != 0) ? (w_sum[ACC_W] ? ACC_MIN : ACC_MAX)
                                                 : w_sum[ACC_W-1:0];

    // Row forward slot: load on accept (even while popping), else drain on pop.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_row_full <= 1'b0;
            r_row_dat  <= '0;
            r_row_last <= 1'b0;
        end else if (w_acc) begin
            r_row_full <= 1'b1;
            r_row_dat  <= bus.row_in_dat;
            r_row_last <= bus.row_in_last;
        end else if (bus.row_out_ready) begin
            r_row_full <= 1'b0;
        end
    end

    // Column forward slot: same policy as the row slot.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_col_full <= 1'b0;
            r_col_dat  <= '0;
        end else if (w_acc) begin
            r_col_full <= 1'b1;
            r_col_dat  <= bus.col_in_dat;
        end else if (bus.col_out_ready) begin
            r_col_full <= 1'b0;
        end
    end

    // Product pipeline: stage 1 takes the fresh product, later stages shift.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
            for (int k = 1; k <= MUL_LAT; k++) r_prod[k] <= '0;
        end else begin
            r_vld_pipe[1]  <= w_acc;
            r_last_pipe[1] <= w_acc & bus.row_in_last;
            if (w_acc) r_prod[1] <= w_prod;
            for (int k = 2; k <= MUL_LAT; k++) begin
                r_vld_pipe[k]  <= r_vld_pipe[k-1];
                r_last_pipe[k] <= r_last_pipe[k-1];
                r_prod[k]      <= r_prod[k-1];
            end
        end
    end

    // Accumulate stage, tile close into the result register, result pop.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_acc          <= '0;
            r_ovf_run      <= 1'b0;
            r_last_pending <= 1'b0;
            r_res_valid    <= 1'b0;
            r_res_dat      <= '0;
            r_res_sat      <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            if (r_res_valid && bus.res_ready) r_res_valid <= 1'b0;
            if (w_acc && bus.row_in_last) r_last_pending <= 1'b1;
            if (w_mac_vld) begin
                r_error <= r_error | w_ovf;
                if (w_mac_last) begin
                    r_res_dat      <= w_acc_nxt;
                    r_res_sat      <= r_ovf_run | w_ovf;
                    r_res_valid    <= 1'b1;
                    r_acc          <= '0;
                    r_ovf_run      <= 1'b0;
                    r_last_pending <= 1'b0;
                end else begin
                    r_acc     <= w_acc_nxt;
                    r_ovf_run <= r_ovf_run | w_ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_pe_mac_stream.sv
// Directed + randomized bench for pe_mac_stream. A scoreboard rebuilds the
// forwarded streams and every dot product from the accepted operand pairs
// using plain integer arithmetic with per-step clamp/wrap.
module tb_pe_mac_stream;
    logic clk = 1'b0;
    logic nrst;
    logic err_m, busy_m, err_s, busy_s, err_w, busy_w;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pe_mac_stream_if #(.DATA_W(8), .ACC_W(32)) u_if   ();
    pe_mac_stream_if #(.DATA_W(8), .ACC_W(16)) u_if_s ();
    pe_mac_stream_if #(.DATA_W(8), .ACC_W(16)) u_if_w ();

    pe_mac_stream #(.DATA_W(8), .ACC_W(32), .MUL_LAT(2), .SATURATE(1)) u_dut (
        .clk(clk), .nrst(nrst), .bus(u_if), .error_bit(err_m), .busy(busy_m));
    pe_mac_stream #(.DATA_W(8), .ACC_W(16), .MUL_LAT(2), .SATURATE(1)) u_dut_s (
        .clk(clk), .nrst(nrst), .bus(u_if_s), .error_bit(err_s), .busy(busy_s));
    pe_mac_stream #(.DATA_W(8), .ACC_W(16), .MUL_LAT(2), .SATURATE(0)) u_dut_w (
        .clk(clk), .nrst(nrst), .bus(u_if_w), .error_bit(err_w), .busy(busy_w));

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference dot product: running sum, clamped or wrapped after every add.
    function automatic void model_tile(input longint p[$], input int w, input bit sat,
                                       output longint res, output bit ovf);
        longint mx  = (longint'(1) << (w - 1)) - 1;
        longint mn  = -(longint'(1) << (w - 1));
        longint rng = mx - mn + 1;
        longint a   = 0;
        ovf = 1'b0;
        foreach (p[i]) begin
            a += p[i];
            if (a > mx || a < mn) begin
                ovf = 1'b1;
                if (sat) a = (a > mx) ? mx : mn;
                else     a = (((a - mn) % rng) + rng) % rng + mn;
            end
        end
        res = a;
    endfunction

    // scoreboard for the main PE
    logic [8:0] row_q [$];
    logic [7:0] col_q [$];
    longint     res_q [$];
    bit         sat_q [$];
    longint     cur   [$];
    longint     m_res;
    bit         m_ovf;
    logic [8:0] e_row;

    always @(negedge clk) begin
        if (nrst) begin
            check("ready_joint", u_if.col_in_ready, u_if.row_in_ready);
            if (u_if.row_in_valid && u_if.row_in_ready) begin
                row_q.push_back({u_if.row_in_last, u_if.row_in_dat});
                col_q.push_back(u_if.col_in_dat);
                cur.push_back(longint'($signed(u_if.row_in_dat)) * longint'($signed(u_if.col_in_dat)));
                if (u_if.row_in_last) begin
                    model_tile(cur, 32, 1'b1, m_res, m_ovf);
                    res_q.push_back(m_res);
                    sat_q.push_back(m_ovf);
                    cur.delete();
                end
            end
            if (u_if.row_out_valid && u_if.row_out_ready) begin
                check("row_out_expected", row_q.size() > 0, 1);
                if (row_q.size() > 0) begin
                    e_row = row_q.pop_front();
                    check("row_out_dat", $signed(u_if.row_out_dat), $signed(e_row[7:0]));
                    check("row_out_last", u_if.row_out_last, e_row[8]);
                end
            end
            if (u_if.col_out_valid && u_if.col_out_ready) begin
                check("col_out_expected", col_q.size() > 0, 1);
                if (col_q.size() > 0) check("col_out_dat", $signed(u_if.col_out_dat), $signed(col_q.pop_front()));
            end
            if (u_if.res_valid && u_if.res_ready) begin
                check("res_expected", res_q.size() > 0, 1);
                if (res_q.size() > 0) begin
                    check("res_dat", $signed(u_if.res_dat), res_q.pop_front());
                    check("res_sat", u_if.res_sat, sat_q.pop_front());
                end
            end
        end
    end

    // Drive one pair and hold it until accepted; returns at accept edge + 1.
    task automatic push(input int r, input int c, input bit l, output int stalls);
        stalls = 0;
        u_if.row_in_valid = 1'b1;
        u_if.col_in_valid = 1'b1;
        u_if.row_in_dat   = 8'(r);
        u_if.col_in_dat   = 8'(c);
        u_if.row_in_last  = l;
        @(negedge clk);
        while (!u_if.row_in_ready && stalls < 50) begin
            @(negedge clk);
            stalls++;
        end
        check("accept_timeout", stalls < 50, 1);
        @(posedge clk); #1;
        u_if.row_in_valid = 1'b0;
        u_if.col_in_valid = 1'b0;
        u_if.row_in_last  = 1'b0;
    endtask

    task automatic wait_res(input string tag);
        int n = 0;
        @(negedge clk);
        while (!u_if.res_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check(tag, u_if.res_valid, 1);
    endtask

    task automatic drive16(input bit v, input int r, input int c, input bit l);
        u_if_s.row_in_valid = v; u_if_s.col_in_valid = v;
        u_if_s.row_in_dat = 8'(r); u_if_s.col_in_dat = 8'(c); u_if_s.row_in_last = l;
        u_if_w.row_in_valid = v; u_if_w.col_in_valid = v;
        u_if_w.row_in_dat = 8'(r); u_if_w.col_in_dat = 8'(c); u_if_w.row_in_last = l;
    endtask

    task automatic flush_model();
        row_q.delete(); col_q.delete(); res_q.delete(); sat_q.delete(); cur.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int rv, cv;
        longint p16 [$];
        longint e_s, e_w;
        bit o_s, o_w;

        // ---- reset state (valids high to show readies stay low) ----
        nrst = 1'b0;
        u_if.row_in_valid = 1'b1; u_if.col_in_valid = 1'b1;
        u_if.row_in_dat = 8'd3; u_if.col_in_dat = 8'd4; u_if.row_in_last = 1'b0;
        u_if.row_out_ready = 1'b1; u_if.col_out_ready = 1'b1; u_if.res_ready = 1'b1;
        drive16(1'b0, 0, 0, 1'b0);
        u_if_s.row_out_ready = 1'b1; u_if_s.col_out_ready = 1'b1; u_if_s.res_ready = 1'b1;
        u_if_w.row_out_ready = 1'b1; u_if_w.col_out_ready = 1'b1; u_if_w.res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_row_out_valid", u_if.row_out_valid, 0);
        check("rst_col_out_valid", u_if.col_out_valid, 0);
        check("rst_res_valid", u_if.res_valid, 0);
        check("rst_res_dat", u_if.res_dat, 0);
        check("rst_row_out_dat", u_if.row_out_dat, 0);
        check("rst_error_bit", err_m, 0);
        check("rst_busy", busy_m, 0);
        check("rst_row_in_ready", u_if.row_in_ready, 0);
        check("rst_col_in_ready", u_if.col_in_ready, 0);
        u_if.row_in_valid = 1'b0; u_if.col_in_valid = 1'b0;
        nrst = 1'b1;
        @(posedge clk); #1;

        // ---- single dot product: 3*4 - 2*5 + 7*7 = 51 ----
        push(3, 4, 1'b0, st);
        push(-2, 5, 1'b0, st);
        push(7, 7, 1'b1, st);
        check("t1_res_valid_e0", u_if.res_valid, 0);
        check("t1_busy", busy_m, 1);
        @(posedge clk); #1;
        check("t1_res_valid_e1", u_if.res_valid, 0);
        @(posedge clk); #1;
        check("t1_res_valid_e2", u_if.res_valid, 1);
        check("t1_res_dat", $signed(u_if.res_dat), 51);
        check("t1_res_sat", u_if.res_sat, 0);
        @(posedge clk); #1;
        check("t1_busy_idle", busy_m, 0);

        // ---- streaming: 8 random pairs, no stalls, forwarded one cycle later ----
        for (int i = 0; i < 8; i++) begin
            rv = $signed(8'($urandom));
            cv = $signed(8'($urandom));
            push(rv, cv, i == 7, st);
            check("t2_no_stall", st, 0);
            check("t2_row_fwd", $signed(u_if.row_out_dat), rv);
            check("t2_col_fwd", $signed(u_if.col_out_dat), cv);
            check("t2_last_fwd", u_if.row_out_last, i == 7);
        end
        wait_res("t2_res_arrives");
        @(posedge clk); #1;

        // ---- backpressure on the south neighbour ----
        u_if.col_out_ready = 1'b0;
        push(11, -7, 1'b0, st);
        u_if.row_in_valid = 1'b1; u_if.col_in_valid = 1'b1;
        u_if.row_in_dat = 8'(12); u_if.col_in_dat = 8'(-8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_row_ready_low", u_if.row_in_ready, 0);
            check("t3_col_ready_low", u_if.col_in_ready, 0);
            check("t3_col_hold", $signed(u_if.col_out_dat), -7);
        end
        @(posedge clk); #1;
        u_if.col_out_ready = 1'b1;
        push(12, -8, 1'b0, st);
        push(13, 9, 1'b1, st);
        wait_res("t3_res_arrives");
        check("t3_res_dat", $signed(u_if.res_dat), -56);
        @(posedge clk); #1;

        // ---- saturate vs wrap at ACC_W=16: 3 x (-128*-128) ----
        for (int i = 0; i < 3; i++) begin
            drive16(1'b1, -128, -128, i == 2);
            p16.push_back(longint'(16384));
            @(negedge clk);
            check("t4_sat_ready", u_if_s.row_in_ready, 1);
            check("t4_wrap_ready", u_if_w.row_in_ready, 1);
            @(posedge clk); #1;
        end
        drive16(1'b0, 0, 0, 1'b0);
        model_tile(p16, 16, 1'b1, e_s, o_s);
        model_tile(p16, 16, 1'b0, e_w, o_w);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t4_sat_valid", u_if_s.res_valid, 1);
        check("t4_sat_dat", $signed(u_if_s.res_dat), e_s);
        check("t4_sat_flag", u_if_s.res_sat, o_s);
        check("t4_sat_error", err_s, 1);
        check("t4_wrap_valid", u_if_w.res_valid, 1);
        check("t4_wrap_dat", $signed(u_if_w.res_dat), e_w);
        check("t4_wrap_flag", u_if_w.res_sat, o_w);
        check("t4_wrap_error", err_w, 1);
        @(posedge clk); #1;

        // ---- result backpressure: tile 2 last waits for tile 1 pop ----
        u_if.res_ready = 1'b0;
        push(2, 3, 1'b0, st);
        push(4, 5, 1'b1, st);
        wait_res("t5_res1_arrives");
        check("t5_res1_dat", $signed(u_if.res_dat), 26);
        @(posedge clk); #1;
        push(1, 2, 1'b0, st);
        check("t5_nonlast_no_stall_a", st, 0);
        push(3, 4, 1'b0, st);
        check("t5_nonlast_no_stall_b", st, 0);
        u_if.row_in_valid = 1'b1; u_if.col_in_valid = 1'b1;
        u_if.row_in_dat = 8'(5); u_if.col_in_dat = 8'(6); u_if.row_in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_last_blocked", u_if.row_in_ready, 0);
            check("t5_res1_hold", $signed(u_if.res_dat), 26);
            check("t5_busy", busy_m, 1);
        end
        @(posedge clk); #1;
        u_if.res_ready = 1'b1;
        push(5, 6, 1'b1, st);
        check("t5_last_after_release", st, 0);
        wait_res("t5_res2_arrives");
        check("t5_res2_dat", $signed(u_if.res_dat), 44);
        @(posedge clk); #1;

        // ---- reset mid-tile, then a fresh one-pair tile ----
        push(5, 6, 1'b0, st);
        push(-3, 2, 1'b0, st);
        nrst = 1'b0;
        flush_model();
        u_if.row_in_valid = 1'b1; u_if.col_in_valid = 1'b1;
        #1;
        check("t6_row_out_valid", u_if.row_out_valid, 0);
        check("t6_col_out_valid", u_if.col_out_valid, 0);
        check("t6_row_out_dat", u_if.row_out_dat, 0);
        check("t6_col_out_dat", u_if.col_out_dat, 0);
        check("t6_res_valid", u_if.res_valid, 0);
        check("t6_busy", busy_m, 0);
        check("t6_ready", u_if.row_in_ready, 0);
        u_if.row_in_valid = 1'b0; u_if.col_in_valid = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        push(1, 1, 1'b1, st);
        wait_res("t6_res_arrives");
        check("t6_res_dat", $signed(u_if.res_dat), 1);
        check("t6_res_sat", u_if.res_sat, 0);

        // ---- drain and final bookkeeping ----
        repeat (4) @(posedge clk);
        #1;
        check("end_row_q_empty", row_q.size(), 0);
        check("end_col_q_empty", col_q.size(), 0);
        check("end_res_q_empty", res_q.size(), 0);
        check("end_busy", busy_m, 0);
        check("end_error_bit", err_m, 0);
        check("end_busy_16", busy_s | busy_w, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
